// File: rtl/axis_cmp_pkg.sv
// Shared types for the AXI4-Stream pair compare scheduler.
// Verdict fields are sized for the largest supported configuration; the top narrows them.
package axis_cmp_pkg;

    localparam int VCHAN_W = 8;
    localparam int VCNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        REPORT
    } state_e;

    typedef struct packed {
        logic [VCHAN_W-1:0] chan;
        logic               equal;
        logic [VCNT_W-1:0]  beats;
    } verdict_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
// On advance the pointer moves to one past the index that was just served.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    input  logic [$clog2(N)-1:0] last_idx,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (last_idx == IW'(N - 1)) ? '0 : last_idx + 1'b1;
        end
    end

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/axis_compare_scheduler.sv
// Time-shares one beat comparator between N_CH A/B stream pairs, a whole packet at a time,
// and reports one verdict per packet on a result stream.
module axis_compare_scheduler
    import axis_cmp_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     en,
    input  logic [N_CH-1:0]          a_valid,
    input  logic [N_CH*DATA_W-1:0]   a_data,
    input  logic [N_CH-1:0]          a_last,
    output logic [N_CH-1:0]          a_ready,
    input  logic [N_CH-1:0]          b_valid,
    input  logic [N_CH*DATA_W-1:0]   b_data,
    input  logic [N_CH-1:0]          b_last,
    output logic [N_CH-1:0]          b_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_CH)-1:0]  res_chan,
    output logic                     res_equal,
    output logic [CNT_W-1:0]         res_beats,
    output logic [CNT_W-1:0]         pkt_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic                     busy
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [VCNT_W-1:0] BEATS_MAX = VCNT_W'((64'd1 << CNT_W) - 64'd1);

    state_e           state_q, state_d;
    verdict_t         vrd_q, vrd_d;
    logic [CNT_W-1:0] pkt_q, pkt_d, fail_q, fail_d;

    logic [N_CH-1:0]   req;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              advance;
    logic [DATA_W-1:0] a_sel, b_sel;
    logic              al_sel, bl_sel, fire, match;

    assign req = a_valid & b_valid;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .advance  (advance),
        .last_idx (vrd_q.chan[CH_W-1:0]),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    // The registered grant selects the datapath; only that pair sees ready, and only as a joined handshake.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        al_sel  = 1'b0;
        bl_sel  = 1'b0;
        a_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (vrd_q.chan == VCHAN_W'(i)) begin
                a_sel      = a_data[i*DATA_W +: DATA_W];
                b_sel      = b_data[i*DATA_W +: DATA_W];
                al_sel     = a_last[i];
                bl_sel     = b_last[i];
                a_ready[i] = (state_q == BUSY) && req[i];
            end
        end
    end

    assign b_ready = a_ready;
    assign fire    = |a_ready;
    assign match   = (a_sel == b_sel) && (al_sel == bl_sel);

    always_comb begin
        state_d = state_q;
        vrd_d   = vrd_q;
        pkt_d   = pkt_q;
        fail_d  = fail_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && gnt_any) begin
                    state_d     = BUSY;
                    vrd_d.chan  = VCHAN_W'(gnt_idx);
                    vrd_d.equal = 1'b1;
                    vrd_d.beats = '0;
                end
            end
            BUSY: begin
                if (fire) begin
                    vrd_d.equal = vrd_q.equal & match;
                    if (vrd_q.beats != BEATS_MAX) vrd_d.beats = vrd_q.beats + 32'd1;
                    if (al_sel || bl_sel) begin
                        state_d = REPORT;
                        pkt_d   = (pkt_q == {CNT_W{1'b1}}) ? pkt_q : pkt_q + 1'b1;
                        if (!vrd_d.equal)
                            fail_d = (fail_q == {CNT_W{1'b1}}) ? fail_q : fail_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = IDLE;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            vrd_q   <= '{chan: '0, equal: 1'b1, beats: '0};
            pkt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vrd_q   <= vrd_d;
            pkt_q   <= pkt_d;
            fail_q  <= fail_d;
        end
    end

    assign res_valid  = (state_q == REPORT);
    assign res_chan   = vrd_q.chan[CH_W-1:0];
    assign res_equal  = vrd_q.equal;
    assign res_beats  = vrd_q.beats[CNT_W-1:0];
    assign pkt_count  = pkt_q;
    assign fail_count = fail_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_axis_compare_scheduler.sv
// Scoreboard bench for axis_compare_scheduler: per-channel beat sources, expected verdicts
// queued when packets are loaded and compared when the result handshake occurs.
module tb_axis_compare_scheduler;

    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic                   clk = 1'b0;
    logic                   resetn, en;
    logic [N_CH-1:0]        a_valid, a_last, a_ready, b_valid, b_last, b_ready;
    logic [N_CH*DATA_W-1:0] a_data, b_data;
    logic                   res_valid, res_ready, res_equal, busy;
    logic [1:0]             res_chan;
    logic [CNT_W-1:0]       res_beats, pkt_count, fail_count;

    always #5 clk = ~clk;

    axis_compare_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .en(en),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
        .res_equal(res_equal), .res_beats(res_beats),
        .pkt_count(pkt_count), .fail_count(fail_count), .busy(busy)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; logic al; logic bl; } beat_t;
    typedef struct { int chan; logic eq; int beats; } exp_t;

    beat_t src_q[N_CH][$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    exp_pkt  = 0;
    int    exp_fail = 0;
    logic  last_pend = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_CH; i++) begin
            if (src_q[i].size() > 0) begin
                a_valid[i] = 1'b1;
                b_valid[i] = 1'b1;
                a_data[i*DATA_W +: DATA_W] = src_q[i][0].a;
                b_data[i*DATA_W +: DATA_W] = src_q[i][0].b;
                a_last[i] = src_q[i][0].al;
                b_last[i] = src_q[i][0].bl;
            end else begin
                a_valid[i] = 1'b0;
                b_valid[i] = 1'b0;
                a_data[i*DATA_W +: DATA_W] = '0;
                b_data[i*DATA_W +: DATA_W] = '0;
                a_last[i] = 1'b0;
                b_last[i] = 1'b0;
            end
        end
    endtask

    task automatic add_beat(int ch, logic [31:0] a, logic [31:0] b, logic al, logic bl);
        beat_t bt;
        bt.a = a; bt.b = b; bt.al = al; bt.bl = bl;
        src_q[ch].push_back(bt);
    endtask

    task automatic add_pkt(int ch, int n, logic [31:0] base);
        for (int k = 0; k < n; k++)
            add_beat(ch, base + k, base + k, k == n - 1, k == n - 1);
    endtask

    task automatic expect_res(int ch, logic eq, int beats);
        exp_t e;
        e.chan = ch; e.eq = eq; e.beats = beats;
        exp_q.push_back(e);
    endtask

    // One clock: observe at the falling edge, then retire consumed beats and re-drive.
    task automatic tick();
        logic [N_CH-1:0] hs;
        logic            lp;
        exp_t            e;
        @(negedge clk);
        hs = a_ready & a_valid & b_valid;
        lp = 1'b0;
        check("rdy_ab_match", b_ready, a_ready);
        check("rdy_multi", ($countones(a_ready) > 1), 0);
        check("rdy_no_req", a_ready & ~(a_valid & b_valid), 0);
        if (last_pend) check("res_latency", res_valid, 1);
        for (int i = 0; i < N_CH; i++)
            if (hs[i] && (a_last[i] || b_last[i])) lp = 1'b1;
        last_pend = lp;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (exp_pkt < 65535) exp_pkt++;
                if (!e.eq && exp_fail < 65535) exp_fail++;
                check("res_chan", res_chan, e.chan);
                check("res_equal", res_equal, e.eq);
                check("res_beats", res_beats, e.beats);
                check("pkt_count", pkt_count, exp_pkt);
                check("fail_count", fail_count, exp_fail);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++)
            if (hs[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0);
        for (int i = 0; i < N_CH; i++)
            if (src_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic drain(int budget);
        for (int c = 0; c < budget && !all_done(); c++) tick();
        if (!all_done()) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_chan", res_chan, 0);
        check("rst_res_equal", res_equal, 1);
        check("rst_res_beats", res_beats, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_fail", fail_count, 0);
        for (int i = 0; i < N_CH; i++) src_q[i].delete();
        exp_q.delete();
        exp_pkt   = 0;
        exp_fail  = 0;
        last_pend = 1'b0;
        drive();
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        en        = 1'b0;
        res_ready = 1'b1;
        drive();
        do_reset();
        en = 1'b1;

        // Single channel, matching 3-beat packet
        add_beat(1, 32'h11, 32'h11, 0, 0);
        add_beat(1, 32'h22, 32'h22, 0, 0);
        add_beat(1, 32'h33, 32'h33, 1, 1);
        expect_res(1, 1, 3);
        drive();
        drain(40);

        // Data mismatch on the middle beat
        add_beat(2, 32'h11, 32'h11, 0, 0);
        add_beat(2, 32'h22, 32'h23, 0, 0);
        add_beat(2, 32'h33, 32'h33, 1, 1);
        expect_res(2, 0, 3);
        drive();
        drain(40);

        // A ends early: packet closes on A's last, last flags disagree
        add_beat(3, 32'h01, 32'h01, 0, 0);
        add_beat(3, 32'h02, 32'h02, 1, 0);
        expect_res(3, 0, 2);
        drive();
        drain(40);

        // All channels request at once; round-robin from pointer 0 after reset
        do_reset();
        add_pkt(0, 1, 32'hA0);
        add_pkt(1, 1, 32'hA1);
        add_beat(2, 32'h07, 32'h08, 1, 1);
        add_pkt(3, 1, 32'hA3);
        add_pkt(0, 1, 32'hB0);
        expect_res(0, 1, 1);
        expect_res(1, 1, 1);
        expect_res(2, 0, 1);
        expect_res(3, 1, 1);
        expect_res(0, 1, 1);
        drive();
        drain(80);

        // Result back-pressure: verdict held, nothing else granted
        res_ready = 1'b0;
        add_pkt(2, 2, 32'h200);
        add_pkt(3, 1, 32'h300);
        expect_res(2, 1, 2);
        expect_res(3, 1, 1);
        drive();
        for (int c = 0; c < 40 && !res_valid; c++) tick();
        check("stall_res_valid", res_valid, 1);
        repeat (5) begin
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_chan", res_chan, 2);
            check("stall_equal", res_equal, 1);
            check("stall_beats", res_beats, 2);
            check("stall_ready", a_ready, 0);
            check("stall_busy", busy, 1);
        end
        res_ready = 1'b1;
        tick();
        check("post_hs_idle", busy, 0);
        check("post_hs_ready", a_ready, 0);
        drain(40);

        // Reset mid-packet abandons it and restarts the pointer at 0
        add_pkt(2, 1, 32'h20);
        expect_res(2, 1, 1);
        drive();
        drain(40);
        add_pkt(3, 4, 32'h40);
        drive();
        for (int c = 0; c < 20 && src_q[3].size() > 2; c++) tick();
        check("mid_pkt_busy", busy, 1);
        do_reset();
        add_pkt(0, 1, 32'h50);
        add_pkt(3, 1, 32'h53);
        expect_res(0, 1, 1);
        expect_res(3, 1, 1);
        drive();
        drain(40);

        // en=0 blocks grants; dropping en mid-packet does not abort it
        en = 1'b0;
        add_pkt(0, 3, 32'h60);
        add_pkt(1, 1, 32'h61);
        add_pkt(2, 1, 32'h62);
        add_pkt(3, 1, 32'h63);
        drive();
        repeat (5) begin
            tick();
            check("en0_busy", busy, 0);
            check("en0_ready", a_ready, 0);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        check("en_grant", busy, 1);
        expect_res(0, 1, 3);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
        check("en0_done", src_q[0].size(), 0);
        repeat (3) begin
            tick();
            check("en0_hold", busy, 0);
        end
        en = 1'b1;
        expect_res(1, 1, 1);
        expect_res(2, 1, 1);
        expect_res(3, 1, 1);
        drain(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
